// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues one imem request at a time and drives the IF/ID register.
// Optional FETCH_PERF_EN adds saturating fetch/bubble counters on perf_fetch_cnt / perf_bubble_cnt.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        pcsrcE,
  input  logic [31:0] pctargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instructd,
  output logic [31:0] pcd,
  output logic [31:0] pc4d,
  output logic        validd
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pc4d_q, pc4d_d;
  logic        valid_q, valid_d;

  logic        load_ok;
  logic        load;
  logic        bubble_wr;
  logic [31:0] load_instr;
  logic [31:0] pc_plus4;
  logic [31:0] tgt_aligned;

  assign load_ok     = !stallD && !flushD;
  assign pc_plus4    = pc_q + 32'd4;
  assign tgt_aligned = {pctargetE[31:2], 2'b00};

  // Fetch FSM: a redirect always wins over a returning word.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    hold_d     = hold_q;
    load       = 1'b0;
    load_instr = hold_q;
    unique case (state_q)
      S_REQ: begin
        if (pcsrcE) begin
          pc_d = tgt_aligned;
        end else if (imem_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (pcsrcE) begin
            pc_d    = tgt_aligned;
            state_d = S_REQ;
          end else if (load_ok) begin
            load       = 1'b1;
            load_instr = imem_rdata;
            pc_d       = pc_plus4;
            state_d    = S_REQ;
          end else begin
            hold_d  = imem_rdata;
            state_d = S_HOLD;
          end
        end else if (pcsrcE) begin
          pc_d    = tgt_aligned;
          state_d = S_DROP;
        end
      end
      S_HOLD: begin
        if (pcsrcE) begin
          pc_d    = tgt_aligned;
          state_d = S_REQ;
        end else if (load_ok) begin
          load       = 1'b1;
          load_instr = hold_q;
          pc_d       = pc_plus4;
          state_d    = S_REQ;
        end
      end
      S_DROP: begin
        if (pcsrcE) begin
          pc_d = tgt_aligned;
        end
        // The response still owed to the old path is consumed here, even if it coincides with a new redirect.
        if (imem_rvalid) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    instr_d   = instr_q;
    pcd_d     = pcd_q;
    pc4d_d    = pc4d_q;
    valid_d   = valid_q;
    bubble_wr = 1'b0;
    if (flushD) begin
      instr_d   = NOP_INSTR;
      valid_d   = 1'b0;
      bubble_wr = 1'b1;
    end else if (stallD) begin
      bubble_wr = 1'b0;
    end else if (load) begin
      instr_d = load_instr;
      pcd_d   = pc_q;
      pc4d_d  = pc_plus4;
      valid_d = 1'b1;
    end else begin
      instr_d   = NOP_INSTR;
      valid_d   = 1'b0;
      bubble_wr = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      hold_q  <= '0;
      instr_q <= NOP_INSTR;
      pcd_q   <= '0;
      pc4d_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      instr_q <= instr_d;
      pcd_q   <= pcd_d;
      pc4d_q  <= pc4d_d;
      valid_q <= valid_d;
    end
  end

  assign imem_req  = (state_q == S_REQ) && !pcsrcE && !rst;
  assign imem_addr = pc_q;
  assign instructd = instr_q;
  assign pcd       = pcd_q;
  assign pc4d      = pc4d_q;
  assign validd    = valid_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (load && (fetch_cnt_q != '1)) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (bubble_wr && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign perf_fetch_cnt  = fetch_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`else
  logic perf_unused;
  assign perf_unused = bubble_wr;
`endif

endmodule
